// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the fetch buffer (instruction queue between fetch and decode).
package fetch_buffer_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(4);
   endfunction

endpackage

// File: rtl/fetch_buffer_mem.sv
// Entry storage for the fetch buffer: one write port, one asynchronous read port, no reset.
module fetch_buffer_mem
   import fetch_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic               clk,
   input  logic               wr_en,
   input  logic [PTR_W-1:0]   wr_addr,
   input  fetch_entry_t       wr_data,
   input  logic [PTR_W-1:0]   rd_addr,
   output fetch_entry_t       rd_data
);

   fetch_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode; back-pressures the PC and empties on flush.
// Optional same-cycle empty-queue bypass is enabled by defining FETCH_BYPASS_EN.
module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                push_i,
   input  logic [ADDR_W-1:0]   pc_i,
   input  logic [INSTR_W-1:0]  instr_i,
   output logic                pc_write_o,
   input  logic                pop_i,
   input  logic                flush_i,
   output logic                valid_o,
   output logic [ADDR_W-1:0]   pc_o,
   output logic [INSTR_W-1:0]  instr_o,
   output logic [ADDR_W-1:0]   pc_plus4_o,
   output logic [PTR_W:0]      count_o
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   logic         full;
   logic         stored_valid;
   logic         push_acc;
   logic         push_wr;
   logic         pop_rd;
   fetch_entry_t wr_entry;
   fetch_entry_t rd_entry;
   fetch_entry_t head;
   logic         head_valid;

   assign full         = (count == FULL_CNT);
   assign stored_valid = (count != '0);
   assign push_acc     = push_i & ~full & ~flush_i;
   assign wr_entry     = '{pc: pc_i, instr: instr_i};

`ifdef FETCH_BYPASS_EN
   logic bypass;
   logic bypass_take;

   // An empty queue forwards the fetched entry; if decode takes it, it is never stored.
   assign bypass      = ~stored_valid & push_i & ~flush_i;
   assign bypass_take = bypass & pop_i;
   assign push_wr     = push_acc & ~bypass_take;
   assign pop_rd      = pop_i & stored_valid & ~flush_i;

   always_comb begin
      head       = rd_entry;
      head_valid = stored_valid;
      if (bypass) begin
         head       = wr_entry;
         head_valid = 1'b1;
      end
      if (!head_valid) begin
         head = '{pc: '0, instr: NOP_INSTR};
      end
   end
`else
   assign push_wr = push_acc;
   assign pop_rd  = pop_i & stored_valid & ~flush_i;

   always_comb begin
      head       = rd_entry;
      head_valid = stored_valid;
      if (!head_valid) begin
         head = '{pc: '0, instr: NOP_INSTR};
      end
   end
`endif

   fetch_buffer_mem #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk     (clk_i),
      .wr_en   (push_wr),
      .wr_addr (wr_ptr),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr),
      .rd_data (rd_entry)
   );

   // Pointer/count state: flush outranks push and pop; pointers wrap naturally.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + {{PTR_W{1'b0}}, push_wr} - {{PTR_W{1'b0}}, pop_rd};
      end
   end

   assign pc_write_o = ~full;
   assign valid_o    = head_valid;
   assign pc_o       = head.pc;
   assign instr_o    = head.instr;
   assign pc_plus4_o = next_pc(head.pc);
   assign count_o    = count;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (default build; FETCH_BYPASS_EN adds bypass checks).
module tb_fetch_buffer;

   logic        clk;
   logic        rst;
   logic        push;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        pc_write;
   logic        pop;
   logic        flush;
   logic        valid;
   logic [31:0] pc_head;
   logic [31:0] instr_head;
   logic [31:0] pc_plus4;
   logic [2:0]  count;

   int checks   = 0;
   int failures = 0;

   fetch_buffer #(.DEPTH(4), .PTR_W(2)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .push_i     (push),
      .pc_i       (pc),
      .instr_i    (instr),
      .pc_write_o (pc_write),
      .pop_i      (pop),
      .flush_i    (flush),
      .valid_o    (valid),
      .pc_o       (pc_head),
      .instr_o    (instr_head),
      .pc_plus4_o (pc_plus4),
      .count_o    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push  = 1'b0;
      pop   = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      pc    = '0;
      instr = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_count", 32'(count), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_pcw", 32'(pc_write), 32'd1);
      check("rst_instr", instr_head, 32'h0);
      check("rst_pc", pc_head, 32'h0);
      check("rst_pc4", pc_plus4, 32'h4);

      // Fill to full
      for (int i = 0; i < 4; i++) begin
         push  = 1'b1;
         pc    = 32'(i * 4);
         instr = 32'h2008_0001 + 32'(i);
         tick();
      end
      check("full_count", 32'(count), 32'd4);
      check("full_pcw", 32'(pc_write), 32'd0);
      check("full_valid", 32'(valid), 32'd1);
      pc    = 32'h10;
      instr = 32'h2008_0005;
      tick();
      push = 1'b0;
      check("drop_count", 32'(count), 32'd4);
      check("drop_head", pc_head, 32'h0);

      // Push with pop while full: push refused, pop happens
      check("pop0_pc", pc_head, 32'h0);
      check("pop0_instr", instr_head, 32'h2008_0001);
      check("pop0_pc4", pc_plus4, 32'h4);
      push = 1'b1;
      pop  = 1'b1;
      tick();
      push = 1'b0;
      pop  = 1'b0;
      check("fullpp_count", 32'(count), 32'd3);
      for (int i = 1; i < 4; i++) begin
         check("popn_pc", pc_head, 32'(i * 4));
         check("popn_instr", instr_head, 32'h2008_0001 + 32'(i));
         check("popn_pc4", pc_plus4, 32'(i * 4 + 4));
         pop = 1'b1;
         tick();
         pop = 1'b0;
      end
      check("drain_count", 32'(count), 32'd0);
      check("drain_valid", 32'(valid), 32'd0);

      // Steady push+pop at count 2 with pointer wrap
      for (int i = 0; i < 2; i++) begin
         push  = 1'b1;
         pc    = 32'h100 + 32'(i * 4);
         instr = (32'h100 + 32'(i * 4)) ^ 32'hABCD_0000;
         tick();
      end
      for (int k = 0; k < 6; k++) begin
         check("pp_head_pc", pc_head, 32'h100 + 32'(k * 4));
         check("pp_head_instr", instr_head, (32'h100 + 32'(k * 4)) ^ 32'hABCD_0000);
         push  = 1'b1;
         pop   = 1'b1;
         pc    = 32'h108 + 32'(k * 4);
         instr = (32'h108 + 32'(k * 4)) ^ 32'hABCD_0000;
         tick();
         check("pp_count", 32'(count), 32'd2);
      end
      pop   = 1'b0;
      pc    = 32'h120;
      instr = 32'h120 ^ 32'hABCD_0000;
      tick();
      check("pre_flush_count", 32'(count), 32'd3);
      check("pre_flush_head", pc_head, 32'h118);

      // Flush beats push and pop in the same cycle
      push  = 1'b1;
      pop   = 1'b1;
      flush = 1'b1;
      pc    = 32'h40;
      instr = 32'h2008_0040;
      tick();
      idle();
      check("flush_count", 32'(count), 32'd0);
      check("flush_valid", 32'(valid), 32'd0);
      check("flush_pcw", 32'(pc_write), 32'd1);
      check("flush_pc", pc_head, 32'h0);
      tick();
      check("flush_no40", pc_head, 32'h0);

      // Pop on empty is ignored
      for (int k = 0; k < 3; k++) begin
         pop = 1'b1;
         tick();
         check("epop_count", 32'(count), 32'd0);
         check("epop_instr", instr_head, 32'h0);
      end
      pop   = 1'b0;
      push  = 1'b1;
      pc    = 32'hFFFF_FFFC;
      instr = 32'h0000_1234;
      tick();
      push = 1'b0;
      check("wrap_count", 32'(count), 32'd1);
      check("wrap_pc", pc_head, 32'hFFFF_FFFC);
      check("wrap_instr", instr_head, 32'h0000_1234);
      check("wrap_pc4", pc_plus4, 32'h0);
      pop = 1'b1;
      tick();
      pop = 1'b0;
      check("wrap_drain", 32'(count), 32'd0);

      // Empty queue: push with pop in the same cycle
      push  = 1'b1;
      pop   = 1'b1;
      pc    = 32'h100;
      instr = 32'h2008_0100;
      #1;
`ifdef FETCH_BYPASS_EN
      check("byp_valid", 32'(valid), 32'd1);
      check("byp_pc", pc_head, 32'h100);
      check("byp_instr", instr_head, 32'h2008_0100);
      tick();
      idle();
      check("byp_count", 32'(count), 32'd0);
      check("byp_valid_next", 32'(valid), 32'd0);
`else
      check("nobyp_valid", 32'(valid), 32'd0);
      check("nobyp_pc", pc_head, 32'h0);
      tick();
      idle();
      check("nobyp_count", 32'(count), 32'd1);
      check("nobyp_valid_next", 32'(valid), 32'd1);
      check("nobyp_pc_next", pc_head, 32'h100);
      pop = 1'b1;
      tick();
      pop = 1'b0;
`endif

      // Asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) begin
         push  = 1'b1;
         pc    = 32'h200 + 32'(i * 4);
         instr = 32'h2008_0200 + 32'(i);
         tick();
      end
      push = 1'b0;
      check("mid_count", 32'(count), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      check("arst_count", 32'(count), 32'd0);
      check("arst_valid", 32'(valid), 32'd0);
      check("arst_pcw", 32'(pc_write), 32'd1);
      check("arst_instr", instr_head, 32'h0);
      tick();
      rst = 1'b0;
      push  = 1'b1;
      pc    = 32'h300;
      instr = 32'h2008_0300;
      tick();
      push = 1'b0;
      check("post_rst_count", 32'(count), 32'd1);
      check("post_rst_pc", pc_head, 32'h300);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got=stalled expected=finish");
      $fatal(1, "timeout");
   end

endmodule
